// File: rtl/cipher_defs.sv
// Shared AES-128 definitions for the key expansion block.
package cipher_defs;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  localparam int unsigned NK = 4;
  localparam int unsigned NR = 10;
  localparam logic [3:0]  LastRound = 4'(NR);

  // Round constants, top byte only; entry 0 is unused.
  localparam logic [10:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  // Out-of-range rounds return zero so the lookup never indexes past the table.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
    return (round > LastRound) ? 8'h00 : RCON[round];
  endfunction

  // Byte left rotate, MSB byte first.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel AES S-box lookups on a 32-bit word.
module sub_word
  import cipher_defs::*;
(
  input  word_t word_in,
  output word_t word_out
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte-wise substitution.
  always_comb begin
    word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
  end

endmodule

// File: rtl/key_expansion.sv
// AES-128 key expansion: emits round keys 0..10 one per accepted handshake.
module key_expansion
  import cipher_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  key_t       cipher_key,
  output logic       rk_valid,
  input  logic       rk_ready,
  output key_t       round_key,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  key_t       key_q, key_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  word_t w0, w1, w2, w3;
  word_t rot_w3, sub_w3, temp;
  word_t n0, n1, n2, n3;
  logic  xfer;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_w3 = rot_word(w3);

  sub_word u_sub_word (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  // Next round key, derived from the current one with the following round's Rcon.
  always_comb begin
    temp = sub_w3 ^ {rcon_lookup(cnt_q + 4'd1), 24'h0};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
  end

  assign xfer = (state_q == StExpand) && rk_ready;

  // Next-state logic: capture on start, advance on each transfer, finish after round 10.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StExpand;
          key_d   = cipher_key;
          cnt_d   = 4'd0;
        end
      end
      StExpand: begin
        if (xfer) begin
          if (cnt_q == LastRound) begin
            // Key and index are left on round 10 for the idle hold.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            key_d = {n0, n1, n2, n3};
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == StExpand);
  assign busy      = (state_q == StExpand);
  assign round_key = key_q;
  assign round_idx = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion against a word-array key schedule model.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;

  key_expansion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cipher_key (cipher_key),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // S-box built from GF(2^8) inverse plus affine map.
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Round key r of the standard 44-word schedule.
  function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    for (int i = 4; i < 4 * r + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level model: which key, which round, running or not.
  logic         m_active;
  logic         m_done;
  int           m_idx;
  logic [127:0] m_base;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_idx    <= 0;
      m_base   <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_idx    <= 0;
          m_base   <= cipher_key;
        end
      end else if (rk_ready) begin
        if (m_idx == 10) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  logic model_ready = 1'b0;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      check("rk_valid", {127'b0, rk_valid}, {127'b0, m_active});
      check("busy", {127'b0, busy}, {127'b0, m_active});
      check("done", {127'b0, done}, {127'b0, m_done});
      check("round_idx", {124'b0, round_idx}, 128'(m_idx));
      check("round_key", round_key, ref_round_key(m_base, m_idx));
    end
  end

  logic [127:0] r1_key, r10_key;
  int           done_cyc;
  logic         saw;

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = calc_sbox(8'(i));
    model_ready = 1'b1;

    // Reset state.
    #3;
    check("reset_valid", {127'b0, rk_valid}, 128'd0);
    check("reset_key", round_key, 128'd0);
    check("reset_idx", {124'b0, round_idx}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 A.1 with rk_ready tied high.
    @(negedge clk);
    rk_ready = 1'b1;
    start = 1'b1;
    cipher_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    r1_key = '0;
    r10_key = '0;
    done_cyc = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid && round_idx == 4'd1) r1_key = round_key;
      if (rk_valid && round_idx == 4'd10) r10_key = round_key;
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    check("fips_round1", r1_key, 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_round10", r10_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_done_cycle", 128'(done_cyc), 128'd12);

    // All-zero key.
    start = 1'b1;
    cipher_key = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_round0", round_key, 128'd0);
    check("zero_valid0", {127'b0, rk_valid}, 128'd1);
    @(negedge clk);
    check("zero_round1", round_key, 128'h62636363626363636263636362636363);
    saw = 1'b0;
    for (int n = 0; n < 20 && !saw; n++) begin
      @(negedge clk);
      saw = done;
    end
    check("zero_done_seen", {127'b0, saw}, 128'd1);

    // Start pulses at rounds 3 and 10 are ignored; start in the done cycle is taken.
    start = 1'b1;
    cipher_key = 128'h000102030405060708090a0b0c0d0e0f;
    saw = 1'b0;
    for (int n = 0; n < 20 && !saw; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        saw = 1'b1;
        start = 1'b1;
        cipher_key = 128'hcafef00d_deadbeef_01234567_89abcdef;
      end else if (rk_valid && (round_idx == 4'd3 || round_idx == 4'd10)) begin
        start = 1'b1;
        cipher_key = 128'hffffffff_00000000_ffffffff_00000000;
      end
    end
    check("pulse_done_seen", {127'b0, saw}, 128'd1);
    @(negedge clk);
    start = 1'b0;
    check("restart_valid", {127'b0, rk_valid}, 128'd1);
    check("restart_idx", {124'b0, round_idx}, 128'd0);
    check("restart_key", round_key, 128'hcafef00d_deadbeef_01234567_89abcdef);

    // Random ready, start and key churn.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rk_ready = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) == 0);
      cipher_key = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    start = 1'b0;
    rk_ready = 1'b1;
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    check("random_drained", {127'b0, busy}, 128'd0);

    // Reset at round 5 aborts the run.
    @(negedge clk);
    start = 1'b1;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    saw = 1'b0;
    for (int n = 0; n < 20 && !saw; n++) begin
      @(negedge clk);
      start = 1'b0;
      saw = rk_valid && (round_idx == 4'd5);
    end
    check("reached_round5", {127'b0, saw}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", {127'b0, rk_valid}, 128'd0);
    check("abort_busy", {127'b0, busy}, 128'd0);
    check("abort_done", {127'b0, done}, 128'd0);
    check("abort_key", round_key, 128'd0);
    check("abort_idx", {124'b0, round_idx}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_no_done", {127'b0, done}, 128'd0);
    start = 1'b1;
    cipher_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(negedge clk);
    start = 1'b0;
    check("post_reset_idx", {124'b0, round_idx}, 128'd0);
    check("post_reset_key", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    repeat (14) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
